// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and load/store.
// One transaction in flight; ISSUE -> WAIT x MEM_LAT -> RESP, with RESP chaining straight into ISSUE.
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ifu_req_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_valid_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_valid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e            state_q;
    logic              ptr_q;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        cnt_q;
    logic              mem_en_q, ifu_gnt_q, lsu_gnt_q, ifu_valid_q, lsu_valid_q;
    logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
    logic              ifu_cand, lsu_cand, pick_lsu_d;
    // the requester completing in RESP still holds req; it only counts again from the next cycle
    assign ifu_cand   = ifu_req_i & ~(state_q == RESP & ~id_q);
    assign lsu_cand   = lsu_req_i & ~(state_q == RESP & id_q);
    assign pick_lsu_d = lsu_cand & (ptr_q | ~ifu_cand);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            ifu_gnt_q   <= 1'b0;
            lsu_gnt_q   <= 1'b0;
            ifu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            ifu_gnt_q   <= 1'b0;
            lsu_gnt_q   <= 1'b0;
            ifu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (ifu_cand | lsu_cand) begin
                        state_q   <= ISSUE;
                        id_q      <= pick_lsu_d;
                        ptr_q     <= ~pick_lsu_d;
                        we_q      <= pick_lsu_d & lsu_we_i;
                        addr_q    <= pick_lsu_d ? lsu_addr_i : ifu_addr_i;
                        wdata_q   <= lsu_wdata_i;
                        mem_en_q  <= 1'b1;
                        lsu_gnt_q <= pick_lsu_d;
                        ifu_gnt_q <= ~pick_lsu_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= 3'(MEM_LAT);
                    state_q <= WAIT;
                end
                default: begin
                    if (cnt_q == 3'd1) begin
                        state_q     <= RESP;
                        lsu_valid_q <= id_q;
                        ifu_valid_q <= ~id_q;
                        if (!we_q && id_q) lsu_rdata_q <= mem_rdata_i;
                        if (!we_q && !id_q) ifu_rdata_q <= mem_rdata_i;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end
    assign ifu_gnt_o   = ifu_gnt_q;
    assign lsu_gnt_o   = lsu_gnt_q;
    assign ifu_valid_o = ifu_valid_q;
    assign lsu_valid_o = lsu_valid_q;
    assign ifu_rdata_o = ifu_rdata_q;
    assign lsu_rdata_o = lsu_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances.
module tb_mem_arbiter;
    typedef struct {bit lsu; bit we; logic [15:0] addr; logic [15:0] wdata; int cyc;} iss_t;
    typedef struct {bit lsu; logic [15:0] rdata; int cyc;} rsp_t;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_pass = 0, n_tot = 0;
    iss_t eiss[$];
    rsp_t ersp[$], ersp3[$];
    iss_t ei;
    rsp_t er, er3;
    logic        ifu_req = 0, lsu_req = 0, lsu_we = 0;
    logic [15:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0;
    logic        ifu_gnt, ifu_valid, lsu_gnt, lsu_valid, mem_en, mem_we, busy;
    logic [15:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        ifu_req3 = 0, lsu_req3 = 0, lsu_we3 = 0;
    logic [15:0] ifu_addr3 = 0, lsu_addr3 = 0, lsu_wdata3 = 0;
    logic        ifu_gnt3, ifu_valid3, lsu_gnt3, lsu_valid3, mem_en3, mem_we3, busy3;
    logic [15:0] ifu_rdata3, lsu_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [15:0] mem [0:255];
    logic [15:0] p0;
    logic [15:0] p3 [3];
    bit inited = 0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) u0 (
        .clk_i(clk), .reset_i(reset),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt), .ifu_rdata_o(ifu_rdata), .ifu_valid_o(ifu_valid),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_gnt_o(lsu_gnt), .lsu_rdata_o(lsu_rdata), .lsu_valid_o(lsu_valid),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy));

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(3)) u3 (
        .clk_i(clk), .reset_i(reset),
        .ifu_req_i(ifu_req3), .ifu_addr_i(ifu_addr3), .ifu_gnt_o(ifu_gnt3), .ifu_rdata_o(ifu_rdata3), .ifu_valid_o(ifu_valid3),
        .lsu_req_i(lsu_req3), .lsu_we_i(lsu_we3), .lsu_addr_i(lsu_addr3), .lsu_wdata_i(lsu_wdata3),
        .lsu_gnt_o(lsu_gnt3), .lsu_rdata_o(lsu_rdata3), .lsu_valid_o(lsu_valid3),
        .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
        .mem_rdata_i(mem_rdata3), .busy_o(busy3));

    // shared memory; read data is poisoned with DEAD except exactly MEM_LAT cycles after mem_en
    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
            mem[0] <= 16'h0D80;
            mem[5] <= 16'hBEEF;
            for (int i = 0; i < 3; i++) begin
                mem[16 + i] <= 16'hA000 + 16'(i);
                mem[32 + i] <= 16'hB000 + 16'(i);
            end
            inited <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        p0    <= mem_en ? mem[mem_addr[7:0]] : 16'hDEAD;
        p3[0] <= mem_en3 ? mem[mem_addr3[7:0]] : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata  = p0;
    assign mem_rdata3 = p3[2];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    always @(negedge clk) begin
        if (mem_en || ifu_gnt || lsu_gnt) begin
            if (eiss.size() == 0) chk("unexpected_issue", 32'(mem_en), 32'(0));
            else begin
                ei = eiss.pop_front();
                chk("iss_mem_en", 32'(mem_en), 32'(1));
                chk("iss_lsu_gnt", 32'(lsu_gnt), 32'(ei.lsu));
                chk("iss_ifu_gnt", 32'(ifu_gnt), 32'(!ei.lsu));
                chk("iss_mem_we", 32'(mem_we), 32'(ei.we));
                chk("iss_mem_addr", 32'(mem_addr), 32'(ei.addr));
                if (ei.we) chk("iss_mem_wdata", 32'(mem_wdata), 32'(ei.wdata));
                chk("iss_cycle", cyc, ei.cyc);
            end
        end
        if (ifu_valid || lsu_valid) begin
            if (ersp.size() == 0) chk("unexpected_valid", {ifu_valid, lsu_valid}, 32'(0));
            else begin
                er = ersp.pop_front();
                chk("rsp_lsu_valid", 32'(lsu_valid), 32'(er.lsu));
                chk("rsp_ifu_valid", 32'(ifu_valid), 32'(!er.lsu));
                chk("rsp_rdata", 32'(er.lsu ? lsu_rdata : ifu_rdata), 32'(er.rdata));
                chk("rsp_cycle", cyc, er.cyc);
            end
        end
        if (ifu_valid3 || lsu_valid3) begin
            if (ersp3.size() == 0) chk("unexpected_valid_l3", {ifu_valid3, lsu_valid3}, 32'(0));
            else begin
                er3 = ersp3.pop_front();
                chk("l3_ifu_valid", 32'(ifu_valid3), 32'(1));
                chk("l3_rdata", 32'(ifu_rdata3), 32'(er3.rdata));
                chk("l3_cycle", cyc, er3.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({busy, ifu_gnt, lsu_gnt, ifu_valid, lsu_valid, mem_en, mem_we}), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_ifu_rdata"}, 32'(ifu_rdata), 32'(0));
        chk({tag, "_lsu_rdata"}, 32'(lsu_rdata), 32'(0));
    endtask

    // single transaction from idle on the MEM_LAT=1 instance; nb counts busy cycles up to valid
    task automatic txn(input bit lsu, input bit we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, output int nb);
        tick();
        eiss.push_back('{lsu, we, a, wd, cyc + 1});
        ersp.push_back('{lsu, exp_rd, cyc + 3});
        if (lsu) begin
            lsu_req = 1; lsu_we = we; lsu_addr = a; lsu_wdata = wd;
        end else begin
            ifu_req = 1; ifu_addr = a;
        end
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nb += int'(busy);
            if (ifu_valid || lsu_valid) break;
        end
        if (!(ifu_valid || lsu_valid)) chk("txn_timeout", 32'(0), 32'(1));
        ifu_req = 0;
        lsu_req = 0;
    endtask

    // both requesters held for n transactions each; LSU is expected to win first
    task automatic both(input int n, input logic [15:0] ib, input logic [15:0] idat,
                        input logic [15:0] lb, input logic [15:0] ldat);
        int k, ni, nl;
        tick();
        k = cyc;
        for (int i = 0; i < n; i++) begin
            eiss.push_back('{1'b1, 1'b0, lb + 16'(i), 16'h0, k + 1 + 6 * i});
            eiss.push_back('{1'b0, 1'b0, ib + 16'(i), 16'h0, k + 4 + 6 * i});
            ersp.push_back('{1'b1, ldat + 16'(i), k + 3 + 6 * i});
            ersp.push_back('{1'b0, idat + 16'(i), k + 6 + 6 * i});
        end
        ifu_req = 1; ifu_addr = ib;
        lsu_req = 1; lsu_we = 0; lsu_addr = lb;
        ni = 0;
        nl = 0;
        for (int c = 0; c < 6 * n + 10 && (ni < n || nl < n); c++) begin
            @(negedge clk);
            if (lsu_valid) begin
                nl++;
                if (nl < n) lsu_addr = lb + 16'(nl);
                else lsu_req = 0;
            end
            if (ifu_valid) begin
                ni++;
                if (ni < n) ifu_addr = ib + 16'(ni);
                else ifu_req = 0;
            end
        end
        if (ni < n || nl < n) chk("both_timeout", 32'(ni + nl), 32'(2 * n));
        ifu_req = 0;
        lsu_req = 0;
    endtask

    initial begin
        int nb, k, en_c;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        chk("reset_busy_l3", 32'(busy3), 32'(0));
        tick();
        reset = 0;
        // single fetch
        txn(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0D80, nb);
        chk("fetch_busy_cycles", nb, 3);
        // store then load; the store must not disturb lsu_rdata
        txn(1'b1, 1'b1, 16'h0005, 16'd14, 16'h0000, nb);
        chk("store_mem5", 32'(mem[5]), 32'd14);
        txn(1'b1, 1'b0, 16'h0005, 16'h0000, 16'd14, nb);
        // pointer now favours IFU; reset must restore LSU priority
        tick();
        reset = 1;
        tick();
        reset = 0;
        both(1, 16'h0000, 16'h0D80, 16'h0005, 16'd14);
        both(3, 16'h0010, 16'hA000, 16'h0020, 16'hB000);
        // reset during WAIT of an LSU load: no valid, outputs cleared, LSU wins next
        tick();
        k = cyc;
        eiss.push_back('{1'b1, 1'b0, 16'h0005, 16'h0, k + 1});
        lsu_req = 1; lsu_we = 0; lsu_addr = 16'h0005;
        tick();
        tick();
        reset = 1;
        lsu_req = 0;
        tick();
        @(negedge clk);
        check_zero("midreset");
        tick();
        reset = 0;
        both(1, 16'h0000, 16'h0D80, 16'h0005, 16'd14);
        // MEM_LAT=3 fetch
        tick();
        k = cyc;
        en_c = -1;
        ersp3.push_back('{1'b0, 16'h0D80, k + 5});
        ifu_req3 = 1;
        ifu_addr3 = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en3 && en_c < 0) en_c = cyc;
            if (ifu_valid3) break;
        end
        if (!ifu_valid3) chk("l3_timeout", 32'(0), 32'(1));
        ifu_req3 = 0;
        chk("l3_mem_en_cycle", en_c, k + 1);
        repeat (4) tick();
        chk("sb_iss_left", eiss.size(), 0);
        chk("sb_rsp_left", ersp.size(), 0);
        chk("sb_rsp3_left", ersp3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
